lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

LCD timing controller on the far side of the LSU's LCD output register. The LSU stores a 32-bit command/data word to the LCD address. `lcd_ctrl` turns each word into a correctly timed HD44780-style write cycle: setup, enable pulse, hold, then instruction execute wait. It exposes a status word that the LSU returns on loads from the LCD status address, so software polls `busy` instead of bit-banging enable timing.

## Interface
- `SETUP_CYC`, 4: cycles RS/DATA are stable before EN rises.
- `EN_CYC`, 12: EN high width in cycles.
- `HOLD_CYC`, 4: cycles RS/DATA are held after EN falls.
- `EXEC_CYC`, 2000: execute wait for normal instructions and data.
- `LONG_EXEC_CYC`, 76000: execute wait for clear/home.
- `INIT_WAIT_CYC`, 750000: power-on wait; used only with `LCD_INIT_SEQ_EN`.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous assert, active-low.
- `i_lcd_wr`, in, 1: one-cycle write strobe from the LSU.
- `i_lcd_word`, in, 32: `[31]` ON, `[30]` CLR_OVF, `[9]` RS, `[7:0]` DATA; all other bits ignored.
- `o_lcd_status`, out, 32: `{29'b0, ovf, pend_v, busy}`.
- `o_lcd_on`, out, 1: display power/backlight.
- `o_lcd_rs`, out, 1: register select.
- `o_lcd_rw`, out, 1: constant 0; the block is write-only.
- `o_lcd_en`, out, 1: enable strobe.
- `o_lcd_data`, out, 8: data bus.

## Operation
- **FSM states:** IDLE, SETUP, EN_HI, HOLD, EXEC. `INIT` also exists under the macro. One down-counter is shared by all states. It is sized for the largest parameter.
- **Pending buffer:** one-entry slot, `pend_v` plus word.
- **Accept rule:** a write with `[30]=0` is accepted if `pend_v==0` or state==IDLE.
  - If a write arrives while `pend_v==1` and state!=IDLE, it is dropped and sticky `ovf` is set.
- **CLR_OVF write** (`[30]=1`): clears `ovf` at that edge and nothing else. It does not transfer, is never queued, and leaves ON unchanged.
- **Launch in IDLE:**
  - If `pend_v`: launch the pending word. A same-cycle write goes into the slot.
  - Else if an accepted write arrives: launch it directly; the slot stays empty.
  - On launch, latch ON, RS and DATA into the output registers, then go to SETUP.
- **State sequence:** SETUP (`SETUP_CYC`) -> EN_HI (`EN_CYC`, `o_lcd_en=1`) -> HOLD (`HOLD_CYC`) -> EXEC -> IDLE.
- **EXEC length:** `LONG_EXEC_CYC` when RS==0, DATA[7:2]==0 and DATA[1:0]!=0 (clear/home). Otherwise `EXEC_CYC`.
- **busy:** 1 in every state except IDLE.
- **Outputs:** RS and DATA hold their last launched values while IDLE.
- **Reset values:** all outputs 0 (`o_lcd_status`, on, rs, rw, en, data). State is IDLE, or INIT with the macro. `pend_v=0`, `ovf=0`, counter 0.
- **Reset mid-operation:** EN drops immediately (async). The in-flight and pending words are discarded.

## Timing
- Write accepted at edge N into an idle, empty block:
  - SETUP from N+1; `busy=1` from N+1.
  - `o_lcd_en` rises at edge N+1+SETUP_CYC and stays high exactly `EN_CYC` cycles.
  - Back to IDLE after SETUP+EN+HOLD+EXEC cycles total.
- Pending word launches on the first edge after IDLE is entered. There is one IDLE cycle between transfers.
- `o_lcd_status` is registered and reflects state after the edge. The LSU load path adds its own latency.
- A write in the same cycle as IDLE-with-pending is accepted; it is not an overflow.

## Configuration
- **`LCD_INIT_SEQ_EN` defined:**
  - Reset enters INIT, with `busy=1` and `o_lcd_on=1`.
  - Wait `INIT_WAIT_CYC`, then issue the internal words RS=0 0x38, 0x0C, 0x01, 0x06 through the normal transfer path with normal EXEC rules.
  - Then go to IDLE.
  - LSU writes during INIT follow the accept rule; pending holds at most one.
- **Not defined:** reset enters IDLE with `busy=0`; no automatic transfers.

## Test plan
- **Single write.** Params 2/3/2/5/9. Reset, then write `0x8000_0241`. Expect RS=1, DATA=0x41, ON=1; EN high exactly 3 cycles, starting 2 cycles after busy rises; busy high 12 cycles.
- **Clear command.** Write `0x0000_0001`. Expect RS=0 and EXEC=9 cycles (busy 16 cycles).
- **Queue and overflow.** Three back-to-back writes while busy.
  - 1st launches, 2nd sets `pend_v`, 3rd dropped, so status=0x7.
  - The 2nd launches after one IDLE cycle.
  - Write `0x4000_0000`: `ovf` clears, no EN pulse.
- **Idle with pending.** Write in the same cycle as IDLE-with-pending. Expect it is accepted, `ovf` stays 0, and it launches after the pending word.
- **Reset mid-transfer.** Assert `i_rst_n=0` during EN_HI. Expect EN, DATA, status and `pend_v` at 0 immediately; no pulse after release.
- **Init sequence.** With `LCD_INIT_SEQ_EN` and `INIT_WAIT_CYC`=20: four EN pulses carrying 0x38, 0x0C, 0x01, 0x06 in order, then busy=0.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns LSU command/data words into timed HD44780-style write cycles with a one-entry pending slot.
// Define LCD_INIT_SEQ_EN to run the power-on wait and init words (0x38, 0x0C, 0x01, 0x06) after reset.
module lcd_ctrl #(
   parameter int SETUP_CYC     = 4,
   parameter int EN_CYC        = 12,
   parameter int HOLD_CYC      = 4,
   parameter int EXEC_CYC      = 2000,
   parameter int LONG_EXEC_CYC = 76000,
   parameter int INIT_WAIT_CYC = 750000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_lcd_wr,
   input  logic [31:0] i_lcd_word,
   output logic [31:0] o_lcd_status,
   output logic        o_lcd_on,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic [7:0]  o_lcd_data
);
   localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
   localparam int MAX_C   = (LONG_EXEC_CYC > INIT_WAIT_CYC) ? LONG_EXEC_CYC : INIT_WAIT_CYC;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EN_HI,
      S_HOLD,
      S_EXEC
`ifdef LCD_INIT_SEQ_EN
      , S_INIT
`endif
   } state_t;

   state_t     state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic       pend_v_q, pend_v_d;
   logic [9:0] pend_word_q, pend_word_d;
   logic       ovf_q, ovf_d;
   logic       on_q, on_d;
   logic       rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic       busy_q, busy_d;
   logic       en_q, en_d;
   logic       launch;
   logic [9:0] launch_word;
   logic       wr_xfer, wr_clr;
   logic [9:0] wr_word;
   logic       is_long;
   logic       unused_word_bits;

`ifdef LCD_INIT_SEQ_EN
   logic [2:0] init_idx_q, init_idx_d;

   // Internal init words are {ON, RS, DATA}; the display stays powered throughout.
   function automatic logic [9:0] init_word(input logic [1:0] idx);
      case (idx)
         2'd0:    init_word = {2'b10, 8'h38};
         2'd1:    init_word = {2'b10, 8'h0C};
         2'd2:    init_word = {2'b10, 8'h01};
         default: init_word = {2'b10, 8'h06};
      endcase
   endfunction
`endif

   assign wr_xfer          = i_lcd_wr & ~i_lcd_word[30];
   assign wr_clr           = i_lcd_wr & i_lcd_word[30];
   assign wr_word          = {i_lcd_word[31], i_lcd_word[9], i_lcd_word[7:0]};
   assign is_long          = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);
   assign unused_word_bits = ^{i_lcd_word[29:10], i_lcd_word[8]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_v_d    = pend_v_q;
      pend_word_d = pend_word_q;
      ovf_d       = ovf_q;
      on_d        = on_q;
      rs_d        = rs_q;
      data_d      = data_q;
      launch      = 1'b0;
      launch_word = '0;
`ifdef LCD_INIT_SEQ_EN
      init_idx_d  = init_idx_q;
`endif

      if (wr_clr) begin
         ovf_d = 1'b0;
      end

      // In IDLE the slot drains first and a same-cycle write refills it; otherwise writes only queue.
      if (state_q == S_IDLE) begin
         if (pend_v_q) begin
            launch      = 1'b1;
            launch_word = pend_word_q;
            pend_v_d    = wr_xfer;
            pend_word_d = wr_word;
         end else if (wr_xfer) begin
            launch      = 1'b1;
            launch_word = wr_word;
         end
      end else if (wr_xfer) begin
         if (pend_v_q) begin
            ovf_d = 1'b1;
         end else begin
            pend_v_d    = 1'b1;
            pend_word_d = wr_word;
         end
      end

      case (state_q)
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_EN_HI;
               cnt_d   = cnt_t'(EN_CYC - 1);
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         S_EN_HI: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = cnt_t'(HOLD_CYC - 1);
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_EXEC;
               cnt_d   = is_long ? cnt_t'(LONG_EXEC_CYC - 1) : cnt_t'(EXEC_CYC - 1);
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
               if (init_idx_q != 3'd4) begin
                  launch      = 1'b1;
                  launch_word = init_word(init_idx_q[1:0]);
                  init_idx_d  = init_idx_q + 3'd1;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = S_IDLE;
`endif
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
`ifdef LCD_INIT_SEQ_EN
         S_INIT: begin
            if (cnt_q == '0) begin
               launch      = 1'b1;
               launch_word = init_word(2'd0);
               init_idx_d  = 3'd1;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
`endif
         default: ;
      endcase

      if (launch) begin
         on_d    = launch_word[9];
         rs_d    = launch_word[8];
         data_d  = launch_word[7:0];
         state_d = S_SETUP;
         cnt_d   = cnt_t'(SETUP_CYC - 1);
      end

      busy_d = (state_d != S_IDLE);
      en_d   = (state_d == S_EN_HI);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
`ifdef LCD_INIT_SEQ_EN
         state_q    <= S_INIT;
         cnt_q      <= cnt_t'(INIT_WAIT_CYC - 1);
         busy_q     <= 1'b1;
         on_q       <= 1'b1;
         init_idx_q <= 3'd0;
`else
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         on_q       <= 1'b0;
`endif
         pend_v_q    <= 1'b0;
         pend_word_q <= '0;
         ovf_q       <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         en_q        <= 1'b0;
      end else begin
`ifdef LCD_INIT_SEQ_EN
         init_idx_q <= init_idx_d;
`endif
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         on_q        <= on_d;
         pend_v_q    <= pend_v_d;
         pend_word_q <= pend_word_d;
         ovf_q       <= ovf_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         en_q        <= en_d;
      end
   end

   assign o_lcd_status = {29'b0, ovf_q, pend_v_q, busy_q};
   assign o_lcd_on     = on_q;
   assign o_lcd_rs     = rs_q;
   assign o_lcd_rw     = 1'b0;
   assign o_lcd_en     = en_q;
   assign o_lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl using short timing (2/3/2/5/9, init wait 20).
// With LCD_INIT_SEQ_EN defined it checks the power-on init sequence instead of the LSU write scenarios.
`timescale 1ns/1ps
module tb_lcd_ctrl;
   logic        clk = 1'b0;
   logic        rstN;
   logic        lcdWr;
   logic [31:0] lcdWord;
   logic [31:0] lcdStatus;
   logic        lcdOn, lcdRs, lcdRw, lcdEn;
   logic [7:0]  lcdData;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] enVec, busyVec;
`ifdef LCD_INIT_SEQ_EN
   int          nPulses = 0;
   logic        prevEn = 1'b0;
   logic [7:0]  seen [4];
   logic [7:0]  initExp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
`endif

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   lcd_ctrl #(
      .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2), .EXEC_CYC(5),
      .LONG_EXEC_CYC(9), .INIT_WAIT_CYC(20)
   ) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_lcd_wr(lcdWr), .i_lcd_word(lcdWord),
      .o_lcd_status(lcdStatus), .o_lcd_on(lcdOn), .o_lcd_rs(lcdRs),
      .o_lcd_rw(lcdRw), .o_lcd_en(lcdEn), .o_lcd_data(lcdData)
   );

   // Advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Present one write word for exactly one sampling edge
   task automatic applyStimulus(input logic [31:0] word);
      lcdWr   = 1'b1;
      lcdWord = word;
      tick();
      lcdWr   = 1'b0;
      lcdWord = '0;
   endtask

   // Record EN and busy over n cycles; bit i is the value seen i edges after the current point
   task automatic captureRun(input int n, output logic [31:0] en, output logic [31:0] busy);
      en   = '0;
      busy = '0;
      for (int i = 0; i < n; i++) begin
         en[i]   = lcdEn;
         busy[i] = lcdStatus[0];
         tick();
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (lcdStatus[0] !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(lcdStatus[0]), 32'h0);
   endtask

   initial begin
      rstN    = 1'b1;
      lcdWr   = 1'b0;
      lcdWord = '0;
      #2 rstN = 1'b0;
      #3;
      $display("[TB] reset asserted");
`ifdef LCD_INIT_SEQ_EN
      checkOutput("rst_status", lcdStatus, 32'h1);
      checkOutput("rst_on", 32'(lcdOn), 32'h1);
      checkOutput("rst_en", 32'(lcdEn), 32'h0);
      checkOutput("rst_rw", 32'(lcdRw), 32'h0);
      tick();
      rstN = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (lcdEn && !prevEn) begin
            if (nPulses < 4) seen[nPulses] = lcdData;
            nPulses++;
         end
         prevEn = lcdEn;
         if (nPulses >= 4 && lcdStatus[0] == 1'b0) break;
         tick();
      end
      checkOutput("init_pulses", 32'(nPulses), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("init_word%0d", i), {24'b0, seen[i]}, {24'b0, initExp[i]});
      end
      checkOutput("init_done_status", lcdStatus, 32'h0);
      checkOutput("init_done_on", 32'(lcdOn), 32'h1);
`else
      checkOutput("rst_status", lcdStatus, 32'h0);
      checkOutput("rst_on", 32'(lcdOn), 32'h0);
      checkOutput("rst_rs", 32'(lcdRs), 32'h0);
      checkOutput("rst_rw", 32'(lcdRw), 32'h0);
      checkOutput("rst_en", 32'(lcdEn), 32'h0);
      checkOutput("rst_data", {24'b0, lcdData}, 32'h0);
      tick();
      rstN = 1'b1;
      tick();

      $display("[TB] single data write");
      applyStimulus(32'h8000_0241);
      checkOutput("single_rs", 32'(lcdRs), 32'h1);
      checkOutput("single_data", {24'b0, lcdData}, 32'h41);
      checkOutput("single_on", 32'(lcdOn), 32'h1);
      checkOutput("single_status", lcdStatus, 32'h1);
      captureRun(16, enVec, busyVec);
      checkOutput("single_en_shape", enVec, 32'h0000_001C);
      checkOutput("single_busy_shape", busyVec, 32'h0000_0FFF);
      waitIdle("single_idle");

      $display("[TB] clear command");
      applyStimulus(32'h0000_0001);
      checkOutput("clear_rs", 32'(lcdRs), 32'h0);
      checkOutput("clear_data", {24'b0, lcdData}, 32'h01);
      checkOutput("clear_on", 32'(lcdOn), 32'h0);
      captureRun(20, enVec, busyVec);
      checkOutput("clear_en_shape", enVec, 32'h0000_001C);
      checkOutput("clear_busy_shape", busyVec, 32'h0000_FFFF);
      waitIdle("clear_idle");

      $display("[TB] queue and overflow");
      applyStimulus(32'h8000_0241);
      applyStimulus(32'h8000_0242);
      applyStimulus(32'h8000_0243);
      checkOutput("queue_status_full", lcdStatus, 32'h7);
      checkOutput("queue_data_first", {24'b0, lcdData}, 32'h41);
      repeat (9) tick();
      checkOutput("queue_status_last_exec", lcdStatus, 32'h7);
      tick();
      checkOutput("queue_status_idle", lcdStatus, 32'h6);
      tick();
      checkOutput("queue_status_second", lcdStatus, 32'h5);
      checkOutput("queue_data_second", {24'b0, lcdData}, 32'h42);
      repeat (12) tick();
      checkOutput("queue_status_done", lcdStatus, 32'h4);
      applyStimulus(32'h4000_0000);
      checkOutput("clrovf_status", lcdStatus, 32'h0);
      checkOutput("clrovf_on", 32'(lcdOn), 32'h1);
      captureRun(20, enVec, busyVec);
      checkOutput("clrovf_no_en", enVec, 32'h0);
      checkOutput("clrovf_no_busy", busyVec, 32'h0);

      $display("[TB] write while idle with pending");
      applyStimulus(32'h8000_0251);
      applyStimulus(32'h8000_0252);
      checkOutput("idlepend_queued", lcdStatus, 32'h3);
      repeat (11) tick();
      checkOutput("idlepend_idle", lcdStatus, 32'h2);
      applyStimulus(32'h8000_0253);
      checkOutput("idlepend_accept", lcdStatus, 32'h3);
      checkOutput("idlepend_data_mid", {24'b0, lcdData}, 32'h52);
      repeat (12) tick();
      checkOutput("idlepend_idle2", lcdStatus, 32'h2);
      tick();
      checkOutput("idlepend_launch3", lcdStatus, 32'h1);
      checkOutput("idlepend_data3", {24'b0, lcdData}, 32'h53);
      waitIdle("idlepend_idle_end");
      checkOutput("idlepend_no_ovf", lcdStatus, 32'h0);

      $display("[TB] reset during enable pulse");
      applyStimulus(32'h8000_0261);
      applyStimulus(32'h8000_0262);
      tick();
      checkOutput("midrst_en_before", 32'(lcdEn), 32'h1);
      checkOutput("midrst_status_before", lcdStatus, 32'h3);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_en", 32'(lcdEn), 32'h0);
      checkOutput("midrst_data", {24'b0, lcdData}, 32'h0);
      checkOutput("midrst_status", lcdStatus, 32'h0);
      checkOutput("midrst_rs", 32'(lcdRs), 32'h0);
      checkOutput("midrst_on", 32'(lcdOn), 32'h0);
      #2 rstN = 1'b1;
      tick();
      captureRun(24, enVec, busyVec);
      checkOutput("midrst_no_pulse", enVec, 32'h0);
      checkOutput("midrst_no_busy", busyVec, 32'h0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
